decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode stage for the RV32I core.
- Sits between fetch and execute and drives the read side of register_file (reg_num_1/reg_num_2 -> rs_1/rs_2).
- Extracts fields and immediates, and tracks pending register writes with a 32-entry busy scoreboard.
- Stalls on RAW/WAW hazards, bypasses same-cycle writeback data, and presents one registered operand bundle to execute under a valid/ready handshake.

Parameters:
XLEN, 32, datapath width (only 32 supported)
REG_COUNT, 32, architectural registers; index width 5

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  decode accepts this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
rf_reg_num_1  out  5  register_file read index 1 (= in_instr[19:15])
rf_reg_num_2  out  5  register_file read index 2 (= in_instr[24:20])
rf_rs_1  in  32  register_file read data 1, combinational, same cycle
rf_rs_2  in  32  register_file read data 2
wb_valid  in  1  writeback retires a register write this cycle
wb_reg_num  in  5  writeback destination
wb_val  in  32  writeback data
flush  in  1  execute redirect; discard held instruction
out_valid  out  1  bundle valid
out_ready  in  1  execute consumes bundle
out_pc  out  32  pc of bundle
out_op_a  out  32  rs1 operand
out_op_b  out  32  rs2 operand
out_imm  out  32  sign-extended immediate
out_rd  out  5  destination index
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7_b5  out  1  instr[30]
out_writes_rd  out  1  bundle writes rd (rd != 0)
out_illegal  out  1  opcode not in RV32I base set

Behaviour:
- Reset (async, rst=1): out_valid=0, all out_* data=0, busy[31:0]=0. in_ready=0 while rst is high. Release is synchronous to clk.
- Decode is combinational on in_instr:
  - uses_rs1: all opcodes except LUI(0110111), AUIPC(0010111), JAL(1101111).
  - uses_rs2: R(0110011), S(0100011), B(1100011).
  - writes_rd: all except S, B; forced 0 when rd=0.
  - Illegal opcode: uses_rs1=uses_rs2=writes_rd=0, out_illegal=1.
- Immediates, sign-extended to 32 bits:
  - I (0010011, 0000011, 1100111, 1110011): instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: 0.
- Operand select per source, with x0 never busy and reading 0:
  - If wb_valid and wb_reg_num==rs and rs!=0: use wb_val (bypass).
  - Else: use rf_rs_N.
  - Unused source: 0.
- hazard = (uses_rs1 & busy[rs1] & !bypass1) | (uses_rs2 & busy[rs2] & !bypass2) | (writes_rd & busy[rd] & !(wb_valid & wb_reg_num==rd)).
- in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, the output register loads the bundle and out_valid=1.
- If out_ready & out_valid & !accept: out_valid=0.
- Outputs hold stable while out_valid & !out_ready.
- Scoreboard, per cycle:
  - Clear busy[wb_reg_num] on wb_valid.
  - Set busy[rd] on accept with writes_rd.
  - Same index set and clear in one cycle: set wins. The WAW stall guarantees the clear belongs to the older write.
- flush=1:
  - Next cycle out_valid=0; nothing accepted this cycle.
  - If out_valid & !out_ready & out_writes_rd, clear busy[out_rd]. The instruction is dropped and will never write back.
  - If out_ready=1 in the flush cycle, the bundle counts as consumed and its busy bit stays set.
- wb_valid with wb_reg_num=0 is ignored.
- Throughput: one instruction per cycle when hazard-free and out_ready=1.
- Latency: 1 cycle from accept to out_valid.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 and busy[3]=1 -> out_valid=0 immediately (async), busy cleared; after release, 0x002081B3 is accepted at once.
- Back-to-back no hazard: addi x1,x0,5 (0x00500093), out_ready=1, rf_rs_1=0 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_writes_rd=1, busy[1]=1.
- RAW stall and bypass:
  - After addi x1, issue add x3,x1,x2 (0x002081B3) with no writeback -> in_ready=0 held.
  - Then wb_valid=1, wb_reg_num=1, wb_val=5 -> accepted that cycle, out_op_a=5; busy[1]=0, busy[3]=1.
- Immediate forms:
  - beq x0,x0,-8 (0xFE000CE3) -> out_imm=0xFFFFFFF8, out_writes_rd=0.
  - lui x5,0x12345 (0x123452B7) -> out_imm=0x12345000, out_op_a=0.
  - sw x2,8(x1) (0x0020A423) -> out_imm=8.
- Backpressure and flush:
  - out_ready=0 with held addi x1 -> outputs stable for 3 cycles.
  - flush=1 -> out_valid=0 next cycle, busy[1]=0.
- Illegal opcode 0x0000007F -> out_illegal=1, out_writes_rd=0, no scoreboard change, never stalls.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch, register-file read, writeback and execute channels seen by decode_stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;

  logic [4:0]      rf_reg_num_1;
  logic [4:0]      rf_reg_num_2;
  logic [XLEN-1:0] rf_rs_1;
  logic [XLEN-1:0] rf_rs_2;

  logic            wb_valid;
  logic [4:0]      wb_reg_num;
  logic [XLEN-1:0] wb_val;

  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op_a;
  logic [XLEN-1:0] out_op_b;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7_b5;
  logic            out_writes_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rs_1, rf_rs_2,
           wb_valid, wb_reg_num, wb_val, flush, out_ready,
    output in_ready, rf_reg_num_1, rf_reg_num_2,
           out_valid, out_pc, out_op_a, out_op_b, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7_b5, out_writes_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rs_1, rf_rs_2,
           wb_valid, wb_reg_num, wb_val, flush, out_ready,
    input  in_ready, rf_reg_num_1, rf_reg_num_2,
           out_valid, out_pc, out_op_a, out_op_b, out_imm, out_rd,
           out_opcode, out_funct3, out_funct7_b5, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate extraction, busy scoreboard with RAW/WAW stall,
// writeback bypass, and a registered operand bundle toward execute.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic [XLEN-1:0]      instr;
  logic [6:0]           opcode;
  logic [4:0]           rs1, rs2, rd;
  logic                 uses_rs1, uses_rs2, writes_any, writes_rd, illegal;
  logic [XLEN-1:0]      imm, op_a, op_b;
  logic                 bypass1, bypass2, wb_hits_rd, hazard;
  logic                 ready, accept, drop_held;
  logic [REG_COUNT-1:0] busy, busy_nxt;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign bus.rf_reg_num_1 = rs1;
  assign bus.rf_reg_num_2 = rs2;

  always_comb begin
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    writes_any = 1'b0;
    illegal    = 1'b0;
    imm        = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        writes_any = 1'b1;
        imm        = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        writes_any = 1'b1;
        imm        = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
        uses_rs1   = 1'b1;
        writes_any = 1'b1;
        imm        = {{20{instr[31]}}, instr[31:20]};
      end
      OP_FENCE: begin
        uses_rs1   = 1'b1;
        writes_any = 1'b1;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_OP: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        writes_any = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    writes_rd = writes_any && (rd != 5'd0);
  end

  assign bypass1    = bus.wb_valid && (bus.wb_reg_num == rs1) && (rs1 != 5'd0);
  assign bypass2    = bus.wb_valid && (bus.wb_reg_num == rs2) && (rs2 != 5'd0);
  assign wb_hits_rd = bus.wb_valid && (bus.wb_reg_num == rd);

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (uses_rs1 && rs1 != 5'd0) op_a = bypass1 ? bus.wb_val : bus.rf_rs_1;
    if (uses_rs2 && rs2 != 5'd0) op_b = bypass2 ? bus.wb_val : bus.rf_rs_2;
  end

  assign hazard = (uses_rs1 && busy[rs1] && !bypass1) ||
                  (uses_rs2 && busy[rs2] && !bypass2) ||
                  (writes_rd && busy[rd] && !wb_hits_rd);

  assign ready        = !rst && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid && ready;
  assign drop_held    = bus.flush && bus.out_valid && !bus.out_ready && bus.out_writes_rd;

  // Order matters: a new set for the same index must override a clear from an older write.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_valid && bus.wb_reg_num != 5'd0) busy_nxt[bus.wb_reg_num] = 1'b0;
    if (drop_held)                              busy_nxt[bus.out_rd]     = 1'b0;
    if (accept && writes_rd)                    busy_nxt[rd]             = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_op_a      <= '0;
      bus.out_op_b      <= '0;
      bus.out_imm       <= '0;
      bus.out_rd        <= '0;
      bus.out_opcode    <= '0;
      bus.out_funct3    <= '0;
      bus.out_funct7_b5 <= 1'b0;
      bus.out_writes_rd <= 1'b0;
      bus.out_illegal   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= bus.in_pc;
      bus.out_op_a      <= op_a;
      bus.out_op_b      <= op_b;
      bus.out_imm       <= imm;
      bus.out_rd        <= rd;
      bus.out_opcode    <= opcode;
      bus.out_funct3    <= instr[14:12];
      bus.out_funct7_b5 <= instr[30];
      bus.out_writes_rd <= writes_rd;
      bus.out_illegal   <= illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: spec-level model of decode, scoreboard and bundle register,
// compared every cycle, plus directed literal checks on the test-plan sequences.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32), .REG_COUNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [31:0] regs [32];
  assign bus.rf_rs_1 = regs[bus.rf_reg_num_1];
  assign bus.rf_rs_2 = regs[bus.rf_reg_num_2];

  typedef struct packed {
    logic        legal;
    logic        r1;
    logic        r2;
    logic        wr;
    logic [31:0] imm;
  } dec_t;

  logic        m_valid, m_f7, m_wr, m_ill;
  logic [31:0] m_pc, m_a, m_b, m_imm, m_busy;
  logic [4:0]  m_rd;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dec_t spec_decode(input logic [31:0] i);
    dec_t d;
    byte fmt;
    logic signed [31:0] s;
    logic [31:0] sx20, sx25, sx31;
    s    = i;
    sx20 = s >>> 20;
    sx25 = s >>> 25;
    sx31 = s >>> 31;
    d = '0;
    d.legal = 1'b1;
    fmt = "N";
    case (i[6:0])
      7'b0110111, 7'b0010111:                       begin d.wr = 1; fmt = "U"; end
      7'b1101111:                                   begin d.wr = 1; fmt = "J"; end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin d.r1 = 1; d.wr = 1; fmt = "I"; end
      7'b0001111:                                   begin d.r1 = 1; d.wr = 1; end
      7'b0100011:                                   begin d.r1 = 1; d.r2 = 1; fmt = "S"; end
      7'b1100011:                                   begin d.r1 = 1; d.r2 = 1; fmt = "B"; end
      7'b0110011:                                   begin d.r1 = 1; d.r2 = 1; d.wr = 1; end
      default:                                      d.legal = 0;
    endcase
    case (fmt)
      "I": d.imm = sx20;
      "S": d.imm = (sx25 << 5) | 32'(i[11:7]);
      "B": d.imm = (sx31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      "U": d.imm = i & 32'hFFFF_F000;
      "J": d.imm = (sx31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: d.imm = 32'd0;
    endcase
    if (i[11:7] == 5'd0) d.wr = 0;
    return d;
  endfunction

  function automatic logic retiring(input logic [4:0] idx);
    return bus.wb_valid && bus.wb_reg_num == idx && idx != 5'd0;
  endfunction

  function automatic logic blocked(input logic [4:0] idx);
    return idx != 5'd0 && m_busy[idx] && !retiring(idx);
  endfunction

  function automatic logic exp_ready();
    dec_t d;
    logic haz;
    d   = spec_decode(bus.in_instr);
    haz = (d.r1 && blocked(bus.in_instr[19:15])) || (d.r2 && blocked(bus.in_instr[24:20])) ||
          (d.wr && blocked(bus.in_instr[11:7]));
    return !rst && !bus.flush && !haz && (!m_valid || bus.out_ready);
  endfunction

  function automatic logic [31:0] operand(input logic used, input logic [4:0] idx);
    if (!used || idx == 5'd0) return 32'd0;
    if (retiring(idx)) return bus.wb_val;
    return regs[idx];
  endfunction

  always @(posedge clk or posedge rst) begin : model
    dec_t d;
    logic acc;
    logic [31:0] a, b;
    if (rst) begin
      m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
      m_opc = 0; m_f3 = 0; m_f7 = 0; m_wr = 0; m_ill = 0; m_busy = 0;
      for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'd0 : 32'h1000 + 32'(k);
    end else begin
      d   = spec_decode(bus.in_instr);
      acc = bus.in_valid && exp_ready();
      a   = operand(d.r1, bus.in_instr[19:15]);
      b   = operand(d.r2, bus.in_instr[24:20]);
      if (bus.wb_valid && bus.wb_reg_num != 5'd0) begin
        m_busy[bus.wb_reg_num] = 1'b0;
        regs[bus.wb_reg_num]   = bus.wb_val;
      end
      if (bus.flush && m_valid && !bus.out_ready && m_wr) m_busy[m_rd] = 1'b0;
      if (acc && d.wr) m_busy[bus.in_instr[11:7]] = 1'b1;
      if (bus.flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_pc = bus.in_pc; m_a = a; m_b = b; m_imm = d.imm;
        m_rd = bus.in_instr[11:7]; m_opc = bus.in_instr[6:0]; m_f3 = bus.in_instr[14:12];
        m_f7 = bus.in_instr[30]; m_wr = d.wr; m_ill = !d.legal;
      end else if (bus.out_ready) m_valid = 0;
    end
  end

  always @(posedge clk) begin
    #4;
    chk("in_ready", bus.in_ready, exp_ready());
    chk("rf_num1", bus.rf_reg_num_1, bus.in_instr[19:15]);
    chk("rf_num2", bus.rf_reg_num_2, bus.in_instr[24:20]);
    chk("out_valid", bus.out_valid, m_valid);
    chk("busy", dut.busy, m_busy);
    chk("out_pc", bus.out_pc, m_pc);
    chk("out_op_a", bus.out_op_a, m_a);
    chk("out_op_b", bus.out_op_b, m_b);
    chk("out_imm", bus.out_imm, m_imm);
    chk("out_rd", bus.out_rd, m_rd);
    chk("out_opcode", bus.out_opcode, m_opc);
    chk("out_funct3", bus.out_funct3, m_f3);
    chk("out_funct7_b5", bus.out_funct7_b5, m_f7);
    chk("out_writes_rd", bus.out_writes_rd, m_wr);
    chk("out_illegal", bus.out_illegal, m_ill);
  end

  logic [31:0] burst [3] = '{32'h00100313, 32'h00200393, 32'h00300413};

  initial begin
    bus.in_valid = 0; bus.in_instr = 32'h00000013; bus.in_pc = 0;
    bus.wb_valid = 0; bus.wb_reg_num = 0; bus.wb_val = 0;
    bus.flush = 0; bus.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_busy", dut.busy, 0);
    rst = 0;

    bus.in_valid = 1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h100;
    @(negedge clk);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_rd", bus.out_rd, 1);
    chk("addi_wr", bus.out_writes_rd, 1);
    chk("addi_busy1", dut.busy[1], 1);

    bus.in_instr = 32'h002081B3; bus.in_pc = 32'h104;
    #1 chk("raw_stall", bus.in_ready, 0);
    @(negedge clk);
    #1 chk("raw_stall_hold", bus.in_ready, 0);
    bus.wb_valid = 1; bus.wb_reg_num = 1; bus.wb_val = 5;
    #1 chk("raw_bypass_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("raw_op_a", bus.out_op_a, 5);
    chk("raw_op_b", bus.out_op_b, 32'h1002);
    chk("raw_busy1", dut.busy[1], 0);
    chk("raw_busy3", dut.busy[3], 1);
    bus.wb_valid = 0;
    #1 chk("waw_stall", bus.in_ready, 0);
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_reg_num = 3; bus.wb_val = 32'h33;
    #1 chk("waw_release", bus.in_ready, 1);
    @(negedge clk);
    chk("waw_set_wins", dut.busy[3], 1);

    bus.in_valid = 0; bus.wb_reg_num = 0; bus.wb_val = 32'hDEAD;
    @(negedge clk);
    bus.wb_valid = 0;

    bus.in_valid = 1; bus.in_instr = 32'hFE000CE3; bus.in_pc = 32'h200;
    @(negedge clk);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("beq_wr", bus.out_writes_rd, 0);
    bus.in_instr = 32'h123452B7; bus.in_pc = 32'h204;
    @(negedge clk);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_op_a", bus.out_op_a, 0);
    bus.in_instr = 32'h0020A423; bus.in_pc = 32'h208;
    @(negedge clk);
    chk("sw_imm", bus.out_imm, 8);

    bus.in_instr = 32'h00500093; bus.in_pc = 32'h20C;
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc", bus.out_pc, 32'h20C);
      chk("bp_imm", bus.out_imm, 5);
      chk("bp_busy1", dut.busy[1], 1);
    end
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_busy1", dut.busy[1], 0);

    bus.out_ready = 1; bus.in_valid = 1; bus.in_instr = 32'h0000007F; bus.in_pc = 32'h300;
    #1 chk("illegal_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("illegal_flag", bus.out_illegal, 1);
    chk("illegal_wr", bus.out_writes_rd, 0);
    chk("illegal_busy", dut.busy, 32'h28);
    bus.in_instr = 32'h00000FFF;
    @(negedge clk);
    chk("illegal_rd31_busy", dut.busy, 32'h28);

    foreach (burst[k]) begin
      bus.in_instr = burst[k]; bus.in_pc = 32'h400 + 32'(k) * 4;
      #1 chk("burst_ready", bus.in_ready, 1);
      @(negedge clk);
    end
    chk("burst_busy", dut.busy, 32'h1E8);

    bus.in_valid = 0; bus.out_ready = 0;
    #2 rst = 1;
    #1 chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_busy", dut.busy, 0);
    @(negedge clk);
    rst = 0;
    bus.in_valid = 1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h500; bus.out_ready = 1;
    #1 chk("post_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_rd", bus.out_rd, 3);
    bus.in_valid = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
